// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch PC sequencer with prefetch FIFO, valid/ready decode handshake and redirect flush (option: FETCH_BOUND_CHECK_EN)
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [2:0]  fifo_count,
  output logic        fetch_fault
);
  localparam int AW = $clog2(FIFO_DEPTH);
  if ((FIFO_DEPTH != 2 && FIFO_DEPTH != 4) || IMEM_WORDS < 1) begin : g_bad_param
    $error("imem_fetch_ctrl: FIFO_DEPTH must be 2 or 4 and IMEM_WORDS positive");
  end
`ifdef FETCH_BOUND_CHECK_EN
  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
`else
  typedef enum logic {IDLE, RUN} state_t;
`endif
  state_t          state;
  logic [31:0]     fetch_pc;
  logic [31:0]     mem_inst [FIFO_DEPTH];
  logic [31:0]     mem_pc   [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [2:0]      count;
  logic            pop, push, oob;
  logic [31:0]     target;
  assign target     = redirect_pc & ~32'h3;
  assign imem_addr  = fetch_pc;
  assign fifo_count = count;
  assign inst_valid = count != 3'd0;
  assign inst_out   = inst_valid ? mem_inst[rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? mem_pc[rd_ptr] : 32'h0;
  // a redirect flushes the head, so a same-cycle handshake is discarded
  assign pop  = inst_valid & inst_ready & ~redirect_valid;
  assign push = state == RUN & fetch_en & ~redirect_valid & ~oob &
                (count < 3'(FIFO_DEPTH) | pop);
`ifdef FETCH_BOUND_CHECK_EN
  logic tgt_oob;
  logic fault_q;
  assign oob         = {2'b00, fetch_pc[31:2]} >= 32'(IMEM_WORDS);
  assign tgt_oob     = {2'b00, target[31:2]} >= 32'(IMEM_WORDS);
  assign fetch_fault = fault_q;
  // control FSM; FAULT is sticky until an in-range redirect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE:    state <= fetch_en ? RUN : IDLE;
        RUN:     if (!fetch_en) state <= IDLE;
                 else if (!redirect_valid && oob) begin
                   state   <= FAULT;
                   fault_q <= 1'b1;
                 end
        FAULT:   if (redirect_valid && !tgt_oob) begin
                   state   <= fetch_en ? RUN : IDLE;
                   fault_q <= 1'b0;
                 end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign oob         = 1'b0;
  assign fetch_fault = 1'b0;
  // control FSM: RUN follows fetch_en, buffered entries drain in either state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= fetch_en ? RUN : IDLE;
  end
`endif
  // fetch PC: redirect wins over sequential advance, wraps silently at the top
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fetch_pc <= RESET_PC;
    else fetch_pc <= redirect_valid ? target : push ? fetch_pc + 32'd4 : fetch_pc;
  end
  // FIFO pointers and occupancy; redirect empties everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 3'd0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 3'd0;
    end else begin
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      count  <= count + {2'b00, push} - {2'b00, pop};
    end
  end
  // FIFO storage; contents are masked by inst_valid so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]   <= fetch_pc;
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  fifo_count;
  logic        fetch_fault;
  int total = 0;
  int bad   = 0;
  imem_fetch_ctrl #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .IMEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fifo_count(fifo_count), .fetch_fault(fetch_fault)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a == 32'h0 ? 32'h00500113 : a == 32'h4 ? 32'h00C00193 : {a[15:0], 16'hBEEF};
  endfunction
  assign imem_rdata = rom(imem_addr);
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask
  initial begin
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    do_reset;
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_out", inst_out, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_cnt", {29'h0, fifo_count}, 32'h0);
    check("rst_fault", {31'h0, fetch_fault}, 32'h0);
    redirect_valid = 1'b0;
    tick;
    check("idle2run_valid", {31'h0, inst_valid}, 32'h0);
    check("idle2run_addr", imem_addr, 32'h0);
    tick;
    check("first_valid", {31'h0, inst_valid}, 32'h1);
    check("first_pc", inst_pc, 32'h0);
    check("first_out", inst_out, 32'h00500113);
    check("first_addr", imem_addr, 32'h4);
    check("first_cnt", {29'h0, fifo_count}, 32'h1);
    tick;
    check("second_pc", inst_pc, 32'h4);
    check("second_out", inst_out, 32'h00C00193);
    check("second_cnt", {29'h0, fifo_count}, 32'h1);
    tick;
    check("third_pc", inst_pc, 32'h8);
    check("third_out", inst_out, rom(32'h8));
    inst_ready = 1'b0;
    do_reset;
    tick;
    tick;
    tick;
    repeat (3) tick;
    check("stall_cnt", {29'h0, fifo_count}, 32'h2);
    check("stall_addr", imem_addr, 32'h8);
    check("stall_head", inst_pc, 32'h0);
    inst_ready = 1'b1;
    tick;
    check("drain_pc4", inst_pc, 32'h4);
    check("drain_cnt", {29'h0, fifo_count}, 32'h2);
    tick;
    check("drain_pc8", inst_pc, 32'h8);
    check("drain_full", {29'h0, fifo_count}, 32'h2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick;
    check("redir_valid", {31'h0, inst_valid}, 32'h0);
    check("redir_cnt", {29'h0, fifo_count}, 32'h0);
    check("redir_addr", imem_addr, 32'h40);
    check("redir_out", inst_out, 32'h0);
    redirect_valid = 1'b0;
    tick;
    check("redir_pc40", inst_pc, 32'h40);
    check("redir_out40", inst_out, rom(32'h40));
    tick;
    check("redir_pc44", inst_pc, 32'h44);
    redirect_valid = 1'b1;
    redirect_pc = 32'h43;
    tick;
    check("align_addr", imem_addr, 32'h40);
    check("align_valid", {31'h0, inst_valid}, 32'h0);
    redirect_valid = 1'b0;
    tick;
    check("align_pc", inst_pc, 32'h40);
    inst_ready = 1'b0;
    tick;
    check("fill_cnt", {29'h0, fifo_count}, 32'h2);
    check("fill_addr", imem_addr, 32'h48);
    fetch_en = 1'b0;
    inst_ready = 1'b1;
    tick;
    check("stop_pc", inst_pc, 32'h44);
    check("stop_cnt", {29'h0, fifo_count}, 32'h1);
    check("stop_addr", imem_addr, 32'h48);
    tick;
    check("empty_valid", {31'h0, inst_valid}, 32'h0);
    check("empty_out", inst_out, 32'h0);
    tick;
    check("frozen_addr", imem_addr, 32'h48);
    check("frozen_cnt", {29'h0, fifo_count}, 32'h0);
    fetch_en = 1'b1;
    tick;
    check("resume_valid", {31'h0, inst_valid}, 32'h0);
    tick;
    check("resume_pc", inst_pc, 32'h48);
    check("resume_out", inst_out, rom(32'h48));
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick;
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    tick;
    check("top_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);
    tick;
    check("wrap_pc", inst_pc, 32'h0);
    check("wrap_out", inst_out, 32'h00500113);
    fetch_en = 1'b0;
    tick;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick;
    redirect_valid = 1'b0;
    check("idle_redir_addr", imem_addr, 32'h100);
    check("idle_redir_valid", {31'h0, inst_valid}, 32'h0);
    tick;
    check("idle_hold_addr", imem_addr, 32'h100);
    check("idle_hold_cnt", {29'h0, fifo_count}, 32'h0);
    fetch_en = 1'b1;
    tick;
    tick;
    check("idle_go_pc", inst_pc, 32'h100);
    check("idle_go_fault", {31'h0, fetch_fault}, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
